// File: rtl/branch_amend_stage_if.sv
// ---------------------------------------------------------------------------
// branch_amend_stage_if
//   Bundles the EXE->PREMEM group payload, the pipeline control inputs and
//   the branch-amend outputs of branch_amend_stage. clk/rst stay plain ports
//   on the stage.
//
//   modport slave  : the branch_amend_stage itself (consumes EXE_*/control,
//                    drives BA_*)
//   modport master : the surrounding pipeline (drives EXE_*/control,
//                    consumes BA_*)
//
//   Per-lane fields are packed [LANES-1:0][width-1:0]; lane 0 is the oldest.
// ---------------------------------------------------------------------------
interface branch_amend_stage_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CKPT_W = 8,
  parameter int unsigned RA_W   = 4
);
  // control
  logic                           CP0_excOccur_w_i;
  logic                           MEM_hasRisk_w_i;
  logic                           REEXE_allowin_w_i;
  logic                           PREMEM_allowin_w_i;

  // EXE group payload
  logic [LANES-1:0]               EXE_valid_w_i;
  logic [LANES-1:0][REG_W-1:0]    EXE_writeNum_i;
  logic [LANES-1:0][DATA_W-1:0]   EXE_VAddr_i;
  logic [LANES-1:0][DATA_W-1:0]   EXE_aluRes_i;
  logic [LANES-1:0][DATA_W-1:0]   EXE_corrDest_i;
  logic [LANES-1:0]               EXE_corrTake_i;
  logic [LANES-1:0][RA_W-1:0]     EXE_repairAction_i;
  logic [LANES-1:0][CKPT_W-1:0]   EXE_checkPoint_i;
  logic [LANES-1:0]               EXE_branchRisk_i;
  logic [LANES-1:0]               EXE_exceptionRisk_i;
  logic [LANES-1:0]               EXE_hasException_i;
  logic [LANES-1:0][4:0]          EXE_ExcCode_i;

  // stage outputs
  logic                           BA_allowin_w_o;
  logic [LANES-1:0]               BA_valid_w_o;
  logic                           BA_hasRisk_w_o;
  logic [LANES-1:0][REG_W-1:0]    BA_writeNum_w_o;
  logic [LANES-1:0][DATA_W-1:0]   BA_forwardData_w_o;
  logic                           BA_flush_w_o;
  logic [DATA_W-1:0]              BA_erroVAddr_w_o;
  logic [DATA_W-1:0]              BA_corrDest_w_o;
  logic                           BA_corrTake_w_o;
  logic [CKPT_W-1:0]              BA_checkPoint_w_o;
  logic [RA_W-1:0]                BA_repairAction_w_o;
  logic [LANES-1:0][REG_W-1:0]    BA_writeNum_o;
  logic [LANES-1:0][DATA_W-1:0]   BA_VAddr_o;
  logic [LANES-1:0][DATA_W-1:0]   BA_aluRes_o;
  logic [LANES-1:0][4:0]          BA_ExcCode_o;
  logic [LANES-1:0]               BA_hasException_o;
  logic [LANES-1:0]               BA_exceptionRisk_o;

  modport slave (
    input  CP0_excOccur_w_i, MEM_hasRisk_w_i, REEXE_allowin_w_i, PREMEM_allowin_w_i,
    input  EXE_valid_w_i, EXE_writeNum_i, EXE_VAddr_i, EXE_aluRes_i,
    input  EXE_corrDest_i, EXE_corrTake_i, EXE_repairAction_i, EXE_checkPoint_i,
    input  EXE_branchRisk_i, EXE_exceptionRisk_i, EXE_hasException_i, EXE_ExcCode_i,
    output BA_allowin_w_o, BA_valid_w_o, BA_hasRisk_w_o, BA_writeNum_w_o,
    output BA_forwardData_w_o, BA_flush_w_o, BA_erroVAddr_w_o, BA_corrDest_w_o,
    output BA_corrTake_w_o, BA_checkPoint_w_o, BA_repairAction_w_o,
    output BA_writeNum_o, BA_VAddr_o, BA_aluRes_o, BA_ExcCode_o,
    output BA_hasException_o, BA_exceptionRisk_o
  );

  modport master (
    output CP0_excOccur_w_i, MEM_hasRisk_w_i, REEXE_allowin_w_i, PREMEM_allowin_w_i,
    output EXE_valid_w_i, EXE_writeNum_i, EXE_VAddr_i, EXE_aluRes_i,
    output EXE_corrDest_i, EXE_corrTake_i, EXE_repairAction_i, EXE_checkPoint_i,
    output EXE_branchRisk_i, EXE_exceptionRisk_i, EXE_hasException_i, EXE_ExcCode_i,
    input  BA_allowin_w_o, BA_valid_w_o, BA_hasRisk_w_o, BA_writeNum_w_o,
    input  BA_forwardData_w_o, BA_flush_w_o, BA_erroVAddr_w_o, BA_corrDest_w_o,
    input  BA_corrTake_w_o, BA_checkPoint_w_o, BA_repairAction_w_o,
    input  BA_writeNum_o, BA_VAddr_o, BA_aluRes_o, BA_ExcCode_o,
    input  BA_hasException_o, BA_exceptionRisk_o
  );
endinterface

// File: rtl/branch_amend_stage.sv
// ---------------------------------------------------------------------------
// branch_amend_stage
//   PREMEM-stage branch-resolution register for a LANES-wide issue group.
//   Latches one group from EXE per handshake, picks the oldest lane whose
//   repair action requests a repair, and raises a one-cycle flush carrying
//   that lane's correct target/checkpoint. While MEM may still raise an
//   exception and a repair is pending, the group is held. Lanes younger than
//   the branch's delay slot are squashed. Per-lane ALU results are forwarded.
//
// Ports
//   clk             clock
//   rst             asynchronous reset, active-low
//   bus (slave)     control inputs, EXE group payload, BA_* outputs
//   BA_mispredCnt_o saturating mispredict-flush counter (optional)
//
// Build option
//   BRANCH_AMEND_PERF_EN : adds BA_mispredCnt_o and its counter.
// ---------------------------------------------------------------------------
module branch_amend_stage #(
  parameter int unsigned LANES      = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned CKPT_W     = 8,
  parameter int unsigned RA_W       = 4,
  parameter int unsigned REPAIR_BIT = 0
) (
  input  logic                clk,
  input  logic                rst,
`ifdef BRANCH_AMEND_PERF_EN
  output logic [31:0]         BA_mispredCnt_o,
`endif
  branch_amend_stage_if.slave bus
);

  localparam int unsigned SEL_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {EMPTY, LOADED} state_t;

  state_t state_q, state_d;

  // group register
  logic [LANES-1:0]             vld_q;
  logic [LANES-1:0][REG_W-1:0]  wnum_q;
  logic [LANES-1:0][DATA_W-1:0] vaddr_q;
  logic [LANES-1:0][DATA_W-1:0] alu_q;
  logic [LANES-1:0][DATA_W-1:0] cdest_q;
  logic [LANES-1:0]             ctake_q;
  logic [LANES-1:0][RA_W-1:0]   ra_q;
  logic [LANES-1:0][CKPT_W-1:0] ckpt_q;
  logic [LANES-1:0]             brisk_q;
  logic [LANES-1:0]             erisk_q;
  logic [LANES-1:0]             hexc_q;
  logic [LANES-1:0][4:0]        exc_q;

  logic             has_data;
  logic [LANES-1:0] rep;
  logic             any_rep;
  logic [SEL_W-1:0] sel;
  logic [31:0]      sel_ext;
  logic             lane_risk;
  logic             ready;
  logic             allowin;
  logic             ok;
  logic             has_risk;
  logic             flush;
  logic [LANES-1:0] valid_lane;
  logic             load;
  logic             clear;

  assign has_data = (state_q == LOADED);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // ------------------------------------------------------- lane qualifiers
  always_comb begin
    rep = '0;
    for (int unsigned i = 0; i < LANES; i++)
      rep[i] = has_data && vld_q[i] && ra_q[i][REPAIR_BIT];
  end

  assign any_rep = |rep;

  always_comb begin
    logic found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (rep[i] && !found) begin
        sel   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

  assign sel_ext = 32'(sel);

  // Only lanes older than the repairing branch can block its flush; with no
  // repair every valid lane counts.
  always_comb begin
    lane_risk = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (vld_q[i] && (!any_rep || (i < sel_ext)))
        lane_risk = lane_risk | brisk_q[i] | erisk_q[i];
    end
  end

  // --------------------------------------------------------- output logic
  always_comb begin
    ready      = !(any_rep && bus.MEM_hasRisk_w_i);
    allowin    = !has_data || (ready && bus.REEXE_allowin_w_i);
    ok         = allowin && bus.PREMEM_allowin_w_i;
    has_risk   = bus.MEM_hasRisk_w_i || lane_risk;
    flush      = has_data && any_rep && !has_risk && ready &&
                 bus.REEXE_allowin_w_i && !bus.CP0_excOccur_w_i;
    valid_lane = '0;
    // The branch lane and its delay slot (sel+1) survive; anything younger
    // is squashed.
    for (int unsigned i = 0; i < LANES; i++)
      valid_lane[i] = has_data && ready && vld_q[i] &&
                      !(any_rep && (i > (sel_ext + 32'd1)));
  end

  // ------------------------------------------------------ next-state logic
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clear   = 1'b0;
    if (bus.CP0_excOccur_w_i || flush) begin
      state_d = EMPTY;
      clear   = 1'b1;
    end else if (ok && (|bus.EXE_valid_w_i)) begin
      state_d = LOADED;
      load    = 1'b1;
    end else if (ok) begin
      state_d = EMPTY;
      clear   = 1'b1;
    end
  end

  // ---------------------------------------------------------- group register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      wnum_q  <= '0;
      vaddr_q <= '0;
      alu_q   <= '0;
      cdest_q <= '0;
      ctake_q <= '0;
      ra_q    <= '0;
      ckpt_q  <= '0;
      brisk_q <= '0;
      erisk_q <= '0;
      hexc_q  <= '0;
      exc_q   <= '0;
    end else if (clear) begin
      vld_q   <= '0;
      wnum_q  <= '0;
      vaddr_q <= '0;
      alu_q   <= '0;
      cdest_q <= '0;
      ctake_q <= '0;
      ra_q    <= '0;
      ckpt_q  <= '0;
      brisk_q <= '0;
      erisk_q <= '0;
      hexc_q  <= '0;
      exc_q   <= '0;
    end else if (load) begin
      vld_q   <= bus.EXE_valid_w_i;
      wnum_q  <= bus.EXE_writeNum_i;
      vaddr_q <= bus.EXE_VAddr_i;
      alu_q   <= bus.EXE_aluRes_i;
      cdest_q <= bus.EXE_corrDest_i;
      ctake_q <= bus.EXE_corrTake_i;
      ra_q    <= bus.EXE_repairAction_i;
      ckpt_q  <= bus.EXE_checkPoint_i;
      brisk_q <= bus.EXE_branchRisk_i;
      erisk_q <= bus.EXE_exceptionRisk_i;
      hexc_q  <= bus.EXE_hasException_i;
      exc_q   <= bus.EXE_ExcCode_i;
    end
  end

  // ------------------------------------------------------------- outputs
  assign bus.BA_allowin_w_o      = allowin;
  assign bus.BA_valid_w_o        = valid_lane;
  assign bus.BA_hasRisk_w_o      = has_risk;
  assign bus.BA_flush_w_o        = flush;
  assign bus.BA_writeNum_w_o     = wnum_q;
  assign bus.BA_forwardData_w_o  = alu_q;

  // sel is 0 when no lane repairs, so these fall back to lane 0.
  assign bus.BA_erroVAddr_w_o    = vaddr_q[sel];
  assign bus.BA_corrDest_w_o     = cdest_q[sel];
  assign bus.BA_corrTake_w_o     = ctake_q[sel];
  assign bus.BA_checkPoint_w_o   = ckpt_q[sel];
  assign bus.BA_repairAction_w_o = ra_q[sel];

  assign bus.BA_writeNum_o       = wnum_q;
  assign bus.BA_VAddr_o          = vaddr_q;
  assign bus.BA_aluRes_o         = alu_q;
  assign bus.BA_ExcCode_o        = exc_q;
  assign bus.BA_hasException_o   = hexc_q;
  assign bus.BA_exceptionRisk_o  = erisk_q;

`ifdef BRANCH_AMEND_PERF_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt_q <= '0;
    else if (flush && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
  end

  assign BA_mispredCnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_branch_amend_stage.sv
// ---------------------------------------------------------------------------
// tb_branch_amend_stage
//   Directed bench for branch_amend_stage: a 2-lane and a 4-lane instance.
//   Expectations are queued as stimulus is driven and drained half a cycle
//   later, away from the active clock edge.
// ---------------------------------------------------------------------------
module tb_branch_amend_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_amend_stage_if #(.LANES(2), .DATA_W(32), .REG_W(5), .CKPT_W(8), .RA_W(4)) b2 ();
  branch_amend_stage_if #(.LANES(4), .DATA_W(32), .REG_W(5), .CKPT_W(8), .RA_W(4)) b4 ();

`ifdef BRANCH_AMEND_PERF_EN
  logic [31:0] cnt2, cnt4;
`endif

  branch_amend_stage #(.LANES(2), .DATA_W(32), .REG_W(5), .CKPT_W(8), .RA_W(4), .REPAIR_BIT(0)) dut2 (
    .clk(clk),
    .rst(rst),
`ifdef BRANCH_AMEND_PERF_EN
    .BA_mispredCnt_o(cnt2),
`endif
    .bus(b2)
  );

  branch_amend_stage #(.LANES(4), .DATA_W(32), .REG_W(5), .CKPT_W(8), .RA_W(4), .REPAIR_BIT(0)) dut4 (
    .clk(clk),
    .rst(rst),
`ifdef BRANCH_AMEND_PERF_EN
    .BA_mispredCnt_o(cnt4),
`endif
    .bus(b4)
  );

  typedef enum int {
    K_VALID2, K_FLUSH2, K_ALLOWIN2, K_RISK2, K_FWD0, K_FWD1, K_WNUM1,
    K_CDEST2, K_CKPT2, K_VADDR2_0, K_VALID4, K_FLUSH4, K_ERRV4, K_CKPT4, K_CNT2
  } kind_t;

  typedef struct {
    string       tag;
    kind_t       kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] observe(input kind_t k);
    case (k)
      K_VALID2:   return 32'(b2.BA_valid_w_o);
      K_FLUSH2:   return 32'(b2.BA_flush_w_o);
      K_ALLOWIN2: return 32'(b2.BA_allowin_w_o);
      K_RISK2:    return 32'(b2.BA_hasRisk_w_o);
      K_FWD0:     return b2.BA_forwardData_w_o[0];
      K_FWD1:     return b2.BA_forwardData_w_o[1];
      K_WNUM1:    return 32'(b2.BA_writeNum_w_o[1]);
      K_CDEST2:   return b2.BA_corrDest_w_o;
      K_CKPT2:    return 32'(b2.BA_checkPoint_w_o);
      K_VADDR2_0: return b2.BA_VAddr_o[0];
      K_VALID4:   return 32'(b4.BA_valid_w_o);
      K_FLUSH4:   return 32'(b4.BA_flush_w_o);
      K_ERRV4:    return b4.BA_erroVAddr_w_o;
      K_CKPT4:    return 32'(b4.BA_checkPoint_w_o);
`ifdef BRANCH_AMEND_PERF_EN
      K_CNT2:     return cnt2;
`endif
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic exp(input string tag, input kind_t k, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t        e;
    logic [31:0] got;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = observe(e.kind);
      n_cmp++;
      assert (got === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, got, e.val);
      end
    end
  endtask

  task automatic clr2();
    b2.EXE_valid_w_i       = '0;
    b2.EXE_writeNum_i      = '0;
    b2.EXE_VAddr_i         = '0;
    b2.EXE_aluRes_i        = '0;
    b2.EXE_corrDest_i      = '0;
    b2.EXE_corrTake_i      = '0;
    b2.EXE_repairAction_i  = '0;
    b2.EXE_checkPoint_i    = '0;
    b2.EXE_branchRisk_i    = '0;
    b2.EXE_exceptionRisk_i = '0;
    b2.EXE_hasException_i  = '0;
    b2.EXE_ExcCode_i       = '0;
  endtask

  task automatic clr4();
    b4.EXE_valid_w_i       = '0;
    b4.EXE_writeNum_i      = '0;
    b4.EXE_VAddr_i         = '0;
    b4.EXE_aluRes_i        = '0;
    b4.EXE_corrDest_i      = '0;
    b4.EXE_corrTake_i      = '0;
    b4.EXE_repairAction_i  = '0;
    b4.EXE_checkPoint_i    = '0;
    b4.EXE_branchRisk_i    = '0;
    b4.EXE_exceptionRisk_i = '0;
    b4.EXE_hasException_i  = '0;
    b4.EXE_ExcCode_i       = '0;
  endtask

  initial begin
    b2.CP0_excOccur_w_i = 1'b0; b2.MEM_hasRisk_w_i = 1'b0;
    b2.REEXE_allowin_w_i = 1'b1; b2.PREMEM_allowin_w_i = 1'b1;
    b4.CP0_excOccur_w_i = 1'b0; b4.MEM_hasRisk_w_i = 1'b0;
    b4.REEXE_allowin_w_i = 1'b1; b4.PREMEM_allowin_w_i = 1'b1;
    clr2();
    clr4();

    // reset state
    @(negedge clk);
    exp("rst_valid", K_VALID2, 32'h0);
    exp("rst_flush", K_FLUSH2, 32'h0);
    exp("rst_allowin", K_ALLOWIN2, 32'h1);
    exp("rst_vaddr", K_VADDR2_0, 32'h0);
    exp("rst_valid4", K_VALID4, 32'h0);
`ifdef BRANCH_AMEND_PERF_EN
    exp("rst_cnt", K_CNT2, 32'h0);
`endif
    check_now();
    @(negedge clk);
    rst = 1'b1;

    // plain ALU group, no repair
    b2.EXE_valid_w_i = 2'b11;
    b2.EXE_writeNum_i[0] = 5'd3;  b2.EXE_writeNum_i[1] = 5'd4;
    b2.EXE_aluRes_i[0] = 32'h1111_2222; b2.EXE_aluRes_i[1] = 32'h3333_4444;
    b2.EXE_VAddr_i[0] = 32'hBFC0_0000;  b2.EXE_VAddr_i[1] = 32'hBFC0_0004;
    exp("alu_allowin_empty", K_ALLOWIN2, 32'h1);
    check_now();
    @(negedge clk);
    clr2();
    exp("alu_valid", K_VALID2, 32'h3);
    exp("alu_flush", K_FLUSH2, 32'h0);
    exp("alu_fwd0", K_FWD0, 32'h1111_2222);
    exp("alu_fwd1", K_FWD1, 32'h3333_4444);
    exp("alu_wnum1", K_WNUM1, 32'h4);
    exp("alu_risk", K_RISK2, 32'h0);
    check_now();
    @(negedge clk);
    exp("alu_drain_valid", K_VALID2, 32'h0);
    exp("alu_drain_allowin", K_ALLOWIN2, 32'h1);
    check_now();

    // lane0 repair held by MEM risk for three cycles
    b2.EXE_valid_w_i = 2'b11;
    b2.EXE_repairAction_i[0] = 4'b0001;
    b2.EXE_corrDest_i[0] = 32'hBFC0_0380;
    b2.EXE_checkPoint_i[0] = 8'h5A;
    b2.EXE_VAddr_i[0] = 32'h8000_0010;
    b2.MEM_hasRisk_w_i = 1'b1;
    exp("hold_load_allowin", K_ALLOWIN2, 32'h1);
    check_now();
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      clr2();
      exp("hold_valid", K_VALID2, 32'h0);
      exp("hold_allowin", K_ALLOWIN2, 32'h0);
      exp("hold_flush", K_FLUSH2, 32'h0);
      exp("hold_risk", K_RISK2, 32'h1);
      check_now();
    end
    @(negedge clk);
    b2.MEM_hasRisk_w_i = 1'b0;
    exp("rel_flush", K_FLUSH2, 32'h1);
    exp("rel_cdest", K_CDEST2, 32'hBFC0_0380);
    exp("rel_ckpt", K_CKPT2, 32'h5A);
    exp("rel_valid", K_VALID2, 32'h3);
    exp("rel_allowin", K_ALLOWIN2, 32'h1);
    check_now();
    @(negedge clk);
    exp("post_flush", K_FLUSH2, 32'h0);
    exp("post_valid", K_VALID2, 32'h0);
    exp("post_vaddr", K_VADDR2_0, 32'h0);
    exp("post_cdest", K_CDEST2, 32'h0);
    check_now();

    // 4 lanes, lane1 repairs: lane3 squashed
    b4.EXE_valid_w_i = 4'b1111;
    b4.EXE_repairAction_i[1] = 4'b0001;
    b4.EXE_VAddr_i[0] = 32'h100; b4.EXE_VAddr_i[1] = 32'h104;
    b4.EXE_VAddr_i[2] = 32'h108; b4.EXE_VAddr_i[3] = 32'h10C;
    b4.EXE_checkPoint_i[0] = 8'h11; b4.EXE_checkPoint_i[1] = 8'hC3;
    b4.EXE_checkPoint_i[2] = 8'h22; b4.EXE_checkPoint_i[3] = 8'h33;
    exp("l4_empty_valid", K_VALID4, 32'h0);
    check_now();
    @(negedge clk);
    clr4();
    exp("l4_valid", K_VALID4, 32'h7);
    exp("l4_errv", K_ERRV4, 32'h104);
    exp("l4_ckpt", K_CKPT4, 32'hC3);
    exp("l4_flush", K_FLUSH4, 32'h1);
    check_now();
    @(negedge clk);
    exp("l4_post_valid", K_VALID4, 32'h0);
    exp("l4_post_flush", K_FLUSH4, 32'h0);
    check_now();

    // older-lane exception risk blocks the flush; REEXE stall holds the group
    b2.EXE_valid_w_i = 2'b11;
    b2.EXE_exceptionRisk_i[0] = 1'b1;
    b2.EXE_repairAction_i[1] = 4'b0001;
    b2.EXE_VAddr_i[0] = 32'h200; b2.EXE_VAddr_i[1] = 32'h204;
    b2.REEXE_allowin_w_i = 1'b0;
    exp("risk_load_allowin", K_ALLOWIN2, 32'h1);
    check_now();
    @(negedge clk);
    clr2();
    exp("risk_has", K_RISK2, 32'h1);
    exp("risk_flush", K_FLUSH2, 32'h0);
    exp("risk_allowin", K_ALLOWIN2, 32'h0);
    exp("risk_valid", K_VALID2, 32'h3);
    check_now();
    @(negedge clk);
    exp("risk_held_vaddr", K_VADDR2_0, 32'h200);
    exp("risk_held_flush", K_FLUSH2, 32'h0);
    exp("risk_held_allowin", K_ALLOWIN2, 32'h0);
    check_now();
    @(negedge clk);
    b2.REEXE_allowin_w_i = 1'b1;
    exp("risk_go_has", K_RISK2, 32'h1);
    exp("risk_go_flush", K_FLUSH2, 32'h0);
    exp("risk_go_allowin", K_ALLOWIN2, 32'h1);
    check_now();
    @(negedge clk);
    exp("risk_post_valid", K_VALID2, 32'h0);
    exp("risk_post_vaddr", K_VADDR2_0, 32'h0);
    check_now();

    // CP0 exception wins over an eligible flush
    b2.EXE_valid_w_i = 2'b01;
    b2.EXE_repairAction_i[0] = 4'b0001;
    b2.EXE_VAddr_i[0] = 32'h300;
    exp("cp0_load_allowin", K_ALLOWIN2, 32'h1);
    check_now();
    @(negedge clk);
    clr2();
    b2.CP0_excOccur_w_i = 1'b1;
    exp("cp0_flush", K_FLUSH2, 32'h0);
    exp("cp0_allowin", K_ALLOWIN2, 32'h1);
    check_now();
    @(negedge clk);
    b2.CP0_excOccur_w_i = 1'b0;
    exp("cp0_post_valid", K_VALID2, 32'h0);
    exp("cp0_post_allowin", K_ALLOWIN2, 32'h1);
    exp("cp0_post_vaddr", K_VADDR2_0, 32'h0);
    check_now();

    // reset asserted mid-HOLD
    b2.EXE_valid_w_i = 2'b11;
    b2.EXE_repairAction_i[0] = 4'b0001;
    b2.EXE_VAddr_i[0] = 32'h400;
    b2.MEM_hasRisk_w_i = 1'b1;
    check_now();
    @(negedge clk);
    clr2();
    exp("rh_hold_valid", K_VALID2, 32'h0);
    exp("rh_hold_allowin", K_ALLOWIN2, 32'h0);
    check_now();
    #2 rst = 1'b0;
    exp("rh_valid", K_VALID2, 32'h0);
    exp("rh_flush", K_FLUSH2, 32'h0);
    exp("rh_allowin", K_ALLOWIN2, 32'h1);
    exp("rh_vaddr", K_VADDR2_0, 32'h0);
`ifdef BRANCH_AMEND_PERF_EN
    exp("rh_cnt", K_CNT2, 32'h0);
`endif
    check_now();
    @(negedge clk);
    b2.MEM_hasRisk_w_i = 1'b0;
    rst = 1'b1;
    exp("rh_rel_flush", K_FLUSH2, 32'h0);
    check_now();

    // five back-to-back mispredicts
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      b2.EXE_valid_w_i = 2'b01;
      b2.EXE_repairAction_i[0] = 4'b0001;
      b2.EXE_corrDest_i[0] = 32'h1000 + 32'(k) * 32'd4;
      check_now();
      @(negedge clk);
      clr2();
      exp("mp_flush", K_FLUSH2, 32'h1);
      exp("mp_cdest", K_CDEST2, 32'h1000 + 32'(k) * 32'd4);
      check_now();
    end
    @(negedge clk);
    exp("mp_after_flush", K_FLUSH2, 32'h0);
`ifdef BRANCH_AMEND_PERF_EN
    exp("mp_cnt5", K_CNT2, 32'd5);
`endif
    check_now();
    #2 rst = 1'b0;
`ifdef BRANCH_AMEND_PERF_EN
    exp("mp_cnt_rst", K_CNT2, 32'd0);
`endif
    exp("mp_rst_allowin", K_ALLOWIN2, 32'h1);
    check_now();
    @(negedge clk);
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_amend_stage.md
# branch_amend_stage

Parametrised PREMEM-stage branch-resolution register for a LANES-wide issue group, successor to the single-lane second-amend stage. Latches one instruction group from EXE_up per handshake, selects the oldest lane whose repair action requests a repair, and issues a single-cycle pipeline flush with that lane's correct target and checkpoint. While MEM reports risk, it holds the group. Lanes younger than the mispredicting branch's delay slot are squashed. It also forwards per-lane ALU results to REEXE.

## Interface
- LANES, 2: issue lanes; lane 0 is the oldest; legal range 1..4
- DATA_W, 32: data and address width
- REG_W, 5: GPR number width; writeNum 0 means no writeback
- CKPT_W, 8: checkpoint width
- RA_W, 4: repair-action width
- REPAIR_BIT, 0: index of the NEED_REPAIR bit within the repair action
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- CP0_excOccur_w_i  in  1  exception flush of the whole pipeline
- MEM_hasRisk_w_i  in  1  MEM stage may still raise an exception
- REEXE_allowin_w_i  in  1  downstream ready
- PREMEM_allowin_w_i  in  1  partner-stage interlock
- EXE_valid_w_i  in  LANES  per-lane valid; group accepted atomically
- EXE_writeNum_i / EXE_VAddr_i / EXE_aluRes_i  in  LANES×(REG_W/DATA_W/DATA_W)  per-lane payload
- EXE_corrDest_i / EXE_corrTake_i / EXE_repairAction_i / EXE_checkPoint_i  in  LANES×(DATA_W/1/RA_W/CKPT_W)  per-lane branch resolution
- EXE_branchRisk_i / EXE_exceptionRisk_i / EXE_hasException_i  in  LANES each  per-lane risk flags
- EXE_ExcCode_i  in  LANES×5  per-lane exception code
- BA_allowin_w_o  out  1  stage can accept a group
- BA_valid_w_o  out  LANES  per-lane valid to REEXE, after squash mask
- BA_hasRisk_w_o  out  1  risk present that blocks the flush
- BA_writeNum_w_o / BA_forwardData_w_o  out  LANES×(REG_W/DATA_W)  forwarding
- BA_flush_w_o  out  1  one-cycle mispredict flush
- BA_erroVAddr_w_o / BA_corrDest_w_o / BA_corrTake_w_o / BA_checkPoint_w_o / BA_repairAction_w_o  out  selected-lane fields
- BA_writeNum_o / BA_VAddr_o / BA_aluRes_o / BA_ExcCode_o / BA_hasException_o / BA_exceptionRisk_o  out  LANES×field  registered payload

## Operation
- State: hasData plus the group register.
  - Derived states: EMPTY (!hasData); RUN (hasData && !hold); HOLD (hasData && anyRep && MEM_hasRisk_w_i).
- Lane qualifiers:
  - rep[i] = lane valid && repairAction[i][REPAIR_BIT].
  - sel = lowest i with rep[i].
  - anyRep = |rep.
- Risk:
  - BA_hasRisk_w_o = MEM_hasRisk_w_i | OR over valid lanes j<sel of (branchRisk|exceptionRisk).
  - With no repair, OR over all valid lanes.
- Handshake:
  - ready = !(anyRep && MEM_hasRisk_w_i).
  - BA_valid_w_o[i] = hasData && ready && lane valid && !(anyRep && i > sel+1).
  - The branch and its delay slot survive.
- Allowin and load:
  - BA_allowin_w_o = !hasData | (ready & REEXE_allowin_w_i).
  - ok = BA_allowin_w_o & PREMEM_allowin_w_i.
- Flush:
  - BA_flush_w_o = hasData & anyRep & !BA_hasRisk_w_o & ready & REEXE_allowin_w_i & !CP0_excOccur_w_i.
  - It asserts at most once per group, in the cycle the group transfers.
- Selected-lane outputs show lane sel, or lane 0 when !anyRep.
- Next-state priority, highest first:
  1. reset
  2. CP0_excOccur_w_i or BA_flush_w_o: clear hasData and the payload to 0
  3. ok && any EXE_valid_w_i: load the group, hasData=1
  4. ok: clear
  5. otherwise hold

## Timing
- Reset, asynchronous:
  - All registered outputs are 0 and hasData=0.
  - BA_allowin_w_o=1; BA_valid_w_o=0; BA_flush_w_o=0.
- Latency: one cycle from EXE acceptance to BA_valid_w_o and BA_flush_w_o.
- Forwarding data is valid in the cycle after load.
- In HOLD, valid=0 and allowin=0. Flush fires in the first cycle the risk drops and REEXE is ready.
- CP0_excOccur_w_i in the same cycle as a pending flush: the exception wins, flush=0, and the register clears at the next edge.
- Reset asserted mid-HOLD: outputs go to reset values immediately, with no flush.

## Configuration
- BRANCH_AMEND_PERF_EN defined:
  - Adds output BA_mispredCnt_o (32 bits), reset to 0.
  - Increments by 1 on every BA_flush_w_o cycle and saturates at 0xFFFFFFFF.
- Undefined: the port and its counter logic are absent, and all other behaviour is identical.

## Test plan
- Group lane0 ALU, lane1 no repair; REEXE ready → next cycle valid=2'b11, flush=0, forwardData matches.
- Lane0 repair, corrDest=0xBFC00380, MEM_hasRisk=1 for 3 cycles → valid=0 and allowin=0 for 3 cycles, then flush=1 for exactly 1 cycle with corrDest=0xBFC00380 and register cleared.
- LANES=4, lane1 repairs → valid=4'b0111, erroVAddr=lane1 VAddr, checkPoint=lane1's.
- Lane0 exceptionRisk=1, lane1 repair → hasRisk=1, flush=0; REEXE_allowin=0 → flush=0 and group held.
- CP0_excOccur_w_i together with an eligible flush → flush=0, next cycle hasData=0, allowin=1.
- With PERF_EN: 5 mispredict flushes → BA_mispredCnt_o=5; reset mid-run → 0.
